// File: rtl/uart_word_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encodings,
// byte-lane geometry of a memory word and the little-endian packing helper.
package uart_word_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE    = 2'd0;
  localparam state_t S_COLLECT = 2'd1;
  localparam state_t S_WRITE   = 2'd2;
  localparam state_t S_DONE    = 2'd3;

  localparam int NUM_LANES  = 4;
  localparam int LANE_IDX_W = 2;

  // First byte received ends up in the least significant lane.
  function automatic logic [31:0] pack_lanes(input logic [7:0] l0,
                                             input logic [7:0] l1,
                                             input logic [7:0] l2,
                                             input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

endpackage

// File: rtl/uart_word_loader_if.sv
// Bundle of the loader's byte-stream input and memory-write/status outputs.
//   i_Rx_DV, i_Rx_Byte : byte strobe and data from the UART receiver
//   o_Wr_En/Addr/Data  : single-cycle memory write
//   o_Word_Count       : words written so far
//   o_Timeout, o_Done  : partial-word discard pulse, load-complete level
// slave  : the loader itself
// master : the byte source / memory side observing the loader
interface uart_word_loader_if #(
  parameter int ADDR_W = 8
);
  logic              i_Rx_DV;
  logic [7:0]        i_Rx_Byte;
  logic              o_Wr_En;
  logic [ADDR_W-1:0] o_Wr_Addr;
  logic [31:0]       o_Wr_Data;
  logic [ADDR_W:0]   o_Word_Count;
  logic              o_Timeout;
  logic              o_Done;

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Word_Count, o_Timeout, o_Done
  );

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Word_Count, o_Timeout, o_Done
  );
endinterface

// File: rtl/uart_byte_packer.sv
// Collects received bytes into four lane registers and watches the gap
// between bytes of one word.
//   i_Clock, i_Rst_n : clock, async active-low reset
//   i_accept         : loader is willing to take a byte this cycle
//   i_Rx_DV/Byte     : byte strobe and data
//   o_word_done      : combinational, the byte being taken fills lane 3
//   o_timeout_hit    : combinational, the partial word is dropped this cycle
//   o_timeout        : registered one-cycle pulse of o_timeout_hit
//   o_word           : assembled word from the lane registers
module uart_byte_packer
  import uart_word_loader_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_accept,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_word_done,
  output logic        o_timeout_hit,
  output logic        o_timeout,
  output logic [31:0] o_word
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS);
  // Dropping on the increment that would reach TIMEOUT_CLKS-1 puts the
  // timeout on idle clock TIMEOUT_CLKS-1 after the last accepted byte.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 2);
  localparam logic [LANE_IDX_W-1:0] IDX_LAST = LANE_IDX_W'(NUM_LANES - 1);

  logic [LANE_IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            lane_q [NUM_LANES];
  logic [7:0]            lane_d [NUM_LANES];
  logic                  timeout_q, timeout_d;
  logic                  take;

  assign take = i_accept & i_Rx_DV;

  always_comb begin
    lane_d        = lane_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    o_word_done   = 1'b0;
    o_timeout_hit = 1'b0;
    if (take) begin
      // A byte always beats an expiring timer in the same cycle.
      lane_d[idx_q] = i_Rx_Byte;
      cnt_d         = '0;
      o_word_done   = (idx_q == IDX_LAST);
      idx_d         = o_word_done ? '0 : idx_q + LANE_IDX_W'(1);
    end else if (idx_q != '0) begin
      if (cnt_q == CNT_LAST) begin
        o_timeout_hit = 1'b1;
        idx_d         = '0;
        cnt_d         = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    timeout_d = o_timeout_hit;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= '0;
    end else begin
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      lane_q    <= lane_d;
    end
  end

  assign o_timeout = timeout_q;
  assign o_word    = pack_lanes(lane_q[0], lane_q[1], lane_q[2], lane_q[3]);

endmodule

// File: rtl/uart_word_loader.sv
// Serial program-load path: packs UART bytes little-endian into 32-bit
// words and writes them to consecutive word addresses from 0 until
// MAX_WORDS words have been written.
//   i_Clock, i_Rst_n : clock, async active-low reset
//   bus (slave)      : byte stream in, memory write and status out
//
// state     | meaning
// S_IDLE    | no partial word held, waiting for lane-0 byte
// S_COLLECT | 1..3 lanes filled, inter-byte timer running
// S_WRITE   | one-cycle memory write of the assembled word
// S_DONE    | MAX_WORDS written, input ignored until reset
module uart_word_loader
  import uart_word_loader_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int MAX_WORDS    = 256,
  parameter int TIMEOUT_CLKS = 1000000
) (
  input  logic               i_Clock,
  input  logic               i_Rst_n,
  uart_word_loader_if.slave  bus
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

  state_t          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            last_word;
  logic            accept;
  logic            word_done;
  logic            timeout_hit;
  logic            timeout_pulse;
  logic [31:0]     word;
  logic            wr_en;
  logic            done;

  assign last_word = (count_q + (ADDR_W + 1)'(1)) == MAX_CNT;
  // The byte arriving during the final write would belong to a word that
  // is never stored, so it is refused.
  assign accept = (state_q != S_DONE) && !((state_q == S_WRITE) && last_word);

  uart_byte_packer #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_packer (
    .i_Clock       (i_Clock),
    .i_Rst_n       (i_Rst_n),
    .i_accept      (accept),
    .i_Rx_DV       (bus.i_Rx_DV),
    .i_Rx_Byte     (bus.i_Rx_Byte),
    .o_word_done   (word_done),
    .o_timeout_hit (timeout_hit),
    .o_timeout     (timeout_pulse),
    .o_word        (word)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_Rx_DV) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (word_done)        state_d = S_WRITE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_WRITE: begin
        count_d = count_q + (ADDR_W + 1)'(1);
        if (last_word)        state_d = S_DONE;
        else if (bus.i_Rx_DV) state_d = S_COLLECT;
        else                  state_d = S_IDLE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_en = (state_q == S_WRITE);
    done  = (state_q == S_DONE);
  end

  // Address is the low bits of the count; at MAX_WORDS == 2**ADDR_W it wraps
  // only on entry to S_DONE, where no further write occurs.
  assign bus.o_Wr_En      = wr_en;
  assign bus.o_Wr_Addr    = count_q[ADDR_W-1:0];
  assign bus.o_Wr_Data    = wr_en ? word : '0;
  assign bus.o_Word_Count = count_q;
  assign bus.o_Timeout    = timeout_pulse;
  assign bus.o_Done       = done;

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader. Two instances share the byte stream; each is
// held in reset while the other is exercised.
//   dut_a : ADDR_W=8, MAX_WORDS=256, TIMEOUT_CLKS=200 (basic, multi-word)
//   dut_b : ADDR_W=1, MAX_WORDS=2,   TIMEOUT_CLKS=50  (timeout, race, done, reset)
module tb_uart_word_loader;

  logic       clk = 1'b0;
  logic       rst_a_n;
  logic       rst_b_n;
  logic       rx_dv;
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  uart_word_loader_if #(.ADDR_W(8)) if_a ();
  uart_word_loader_if #(.ADDR_W(1)) if_b ();

  assign if_a.i_Rx_DV   = rx_dv;
  assign if_a.i_Rx_Byte = rx_byte;
  assign if_b.i_Rx_DV   = rx_dv;
  assign if_b.i_Rx_Byte = rx_byte;

  uart_word_loader #(.ADDR_W(8), .MAX_WORDS(256), .TIMEOUT_CLKS(200)) dut_a (
    .i_Clock (clk),
    .i_Rst_n (rst_a_n),
    .bus     (if_a)
  );

  uart_word_loader #(.ADDR_W(1), .MAX_WORDS(2), .TIMEOUT_CLKS(50)) dut_b (
    .i_Clock (clk),
    .i_Rst_n (rst_b_n),
    .bus     (if_b)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_a[$];
  wr_t  exp_b[$];
  int   n_vec    = 0;
  int   n_miss   = 0;
  int   to_cnt_a = 0;
  int   to_cnt_b = 0;
  int   wr_cnt_b = 0;
  int   idle_k   = 0;
  logic dv_at_edge = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // dv_at_edge: DV was sampled at the most recent rising edge.
  // idle_k: rising edges since the last sampled DV.
  always @(posedge clk) begin
    dv_at_edge <= rx_dv;
    idle_k     <= rx_dv ? 0 : idle_k + 1;
  end

  always @(negedge clk) begin
    wr_t e;
    if (if_a.o_Wr_En) begin
      chk("wr_to_excl_a", if_a.o_Timeout, 0);
      if (exp_a.size() == 0) begin
        chk("wr_unexp_a", if_a.o_Wr_En, 0);
      end else begin
        e = exp_a.pop_front();
        chk("wr_addr_a", if_a.o_Wr_Addr, e.addr);
        chk("wr_data_a", if_a.o_Wr_Data, e.data);
        chk("wr_lat_a", dv_at_edge, 1);
      end
    end
    if (if_a.o_Timeout) to_cnt_a++;
  end

  always @(negedge clk) begin
    wr_t e;
    if (if_b.o_Wr_En) begin
      wr_cnt_b++;
      chk("wr_to_excl_b", if_b.o_Timeout, 0);
      if (exp_b.size() == 0) begin
        chk("wr_unexp_b", if_b.o_Wr_En, 0);
      end else begin
        e = exp_b.pop_front();
        chk("wr_addr_b", if_b.o_Wr_Addr, e.addr);
        chk("wr_data_b", if_b.o_Wr_Data, e.data);
        chk("wr_lat_b", dv_at_edge, 1);
      end
    end
    if (if_b.o_Timeout) begin
      to_cnt_b++;
      chk("to_idle_clk_b", idle_k, 49);
    end
  end

  // Called at a falling edge: DV high for one cycle, then gap idle cycles.
  // gap=0 keeps DV high into the next byte. Returns at a falling edge.
  task automatic send(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_byte = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    n_miss++;
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_wr_en",  if_a.o_Wr_En, 0);
    chk("rst_addr",   if_a.o_Wr_Addr, 0);
    chk("rst_data",   if_a.o_Wr_Data, 0);
    chk("rst_count",  if_a.o_Word_Count, 0);
    chk("rst_tmo",    if_a.o_Timeout, 0);
    chk("rst_done",   if_a.o_Done, 0);

    // Basic word, bytes 100 clocks apart.
    rst_a_n = 1'b1;
    @(negedge clk);
    exp_a.push_back('{0, 32'h1234_5678});
    send(8'h78, 99);
    send(8'h56, 99);
    send(8'h34, 99);
    send(8'h12, 0);
    repeat (2) @(negedge clk);
    chk("basic_count", if_a.o_Word_Count, 1);
    chk("basic_sb",    exp_a.size(), 0);

    // Three words back-to-back, fresh from reset.
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    for (int w = 0; w < 3; w++) begin
      d = $urandom;
      exp_a.push_back('{w, d});
      for (int i = 0; i < 4; i++) send(d[8*i +: 8], 0);
    end
    repeat (3) @(negedge clk);
    chk("multi_count", if_a.o_Word_Count, 3);
    chk("multi_sb",    exp_a.size(), 0);
    chk("multi_tmo",   to_cnt_a, 0);
    rst_a_n = 1'b0;

    // Timeout: two bytes then silence.
    rst_b_n = 1'b1;
    send(8'hAA, 1);
    send(8'hBB, 0);
    repeat (60) @(negedge clk);
    chk("tmo_pulses", to_cnt_b, 1);
    chk("tmo_no_wr",  wr_cnt_b, 0);
    chk("tmo_count",  if_b.o_Word_Count, 0);
    exp_b.push_back('{0, 32'h0403_0201});
    send(8'h01, 2);
    send(8'h02, 2);
    send(8'h03, 2);
    send(8'h04, 3);
    chk("tmo_after_count", if_b.o_Word_Count, 1);

    // Race: second byte lands on idle clock 49; it completes the last word.
    exp_b.push_back('{1, 32'h4030_2010});
    send(8'h10, 48);
    send(8'h20, 2);
    send(8'h30, 2);
    send(8'h40, 0);
    chk("race_wr_en",   if_b.o_Wr_En, 1);
    chk("done_at_wr",   if_b.o_Done, 0);
    @(negedge clk);
    chk("done_rise",    if_b.o_Done, 1);
    chk("race_no_tmo",  to_cnt_b, 1);

    // Bytes after done are ignored.
    for (int i = 0; i < 4; i++) send(8'($urandom), 1);
    repeat (60) @(negedge clk);
    chk("done_count",  if_b.o_Word_Count, 2);
    chk("done_writes", wr_cnt_b, 2);
    chk("done_level",  if_b.o_Done, 1);
    chk("done_no_tmo", to_cnt_b, 1);

    // Asynchronous reset between clock edges.
    #2 rst_b_n = 1'b0;
    #1;
    chk("arst_done",  if_b.o_Done, 0);
    chk("arst_count", if_b.o_Word_Count, 0);
    chk("arst_wr_en", if_b.o_Wr_En, 0);
    chk("arst_data",  if_b.o_Wr_Data, 0);
    @(negedge clk);
    rst_b_n = 1'b1;

    // Reset mid-word drops the partial word.
    send(8'h11, 1);
    send(8'h22, 1);
    #1 rst_b_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", if_b.o_Wr_En, 0);
    @(negedge clk);
    rst_b_n = 1'b1;
    exp_b.push_back('{0, 32'hEFBE_ADDE});
    send(8'hDE, 1);
    send(8'hAD, 1);
    send(8'hBE, 1);
    send(8'hEF, 3);
    chk("post_rst_count", if_b.o_Word_Count, 1);
    chk("post_rst_sb",    exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
